// File: rtl/md_pkg.sv
`default_nettype none
// ============================================================================
// md_pkg
// Shared op encoding, state type and op classification for the MD unit.
// Revision: 1.0
// ============================================================================
package md_pkg;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;
  localparam logic [2:0] OP_MFHI  = 3'd6;
  localparam logic [2:0] OP_MFLO  = 3'd7;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_e;

  // Multi-cycle ops are exactly the encodings with op[2] clear.
  function automatic logic is_md_long(input logic [2:0] op);
    return (op[2] == 1'b0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/md_arith.sv
`default_nettype none
// ============================================================================
// md_arith
// Combinational signed/unsigned multiply and divide datapath.
// Revision: 1.0
// ============================================================================
module md_arith
  import md_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo,
  output logic        div_zero
);

  logic [63:0] w_prod_s;
  logic [63:0] w_prod_u;
  logic        w_signed_div;
  logic        w_a_neg;
  logic        w_b_neg;
  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;
  logic [31:0] w_b_safe;
  logic [31:0] w_q_mag;
  logic [31:0] w_r_mag;

  assign w_prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
  assign w_prod_u = {32'd0, a} * {32'd0, b};

  // Divide on magnitudes so the 0x80000000 / -1 case wraps cleanly.
  assign w_signed_div = (op == OP_DIV);
  assign w_a_neg      = w_signed_div & a[31];
  assign w_b_neg      = w_signed_div & b[31];
  assign w_a_mag      = w_a_neg ? (32'd0 - a) : a;
  assign w_b_mag      = w_b_neg ? (32'd0 - b) : b;
  assign div_zero     = (b == 32'd0);
  // Divisor forced to 1 when zero; the result is discarded at commit anyway.
  assign w_b_safe     = div_zero ? 32'd1 : w_b_mag;
  assign w_q_mag      = w_a_mag / w_b_safe;
  assign w_r_mag      = w_a_mag % w_b_safe;

  // Select product or quotient/remainder by op.
  always_comb begin
    res_hi = 32'd0;
    res_lo = 32'd0;
    case (op)
      OP_MULT: begin
        res_hi = w_prod_s[63:32];
        res_lo = w_prod_s[31:0];
      end
      OP_MULTU: begin
        res_hi = w_prod_u[63:32];
        res_lo = w_prod_u[31:0];
      end
      OP_DIV, OP_DIVU: begin
        res_lo = (w_a_neg ^ w_b_neg) ? (32'd0 - w_q_mag) : w_q_mag;
        res_hi = w_a_neg ? (32'd0 - w_r_mag) : w_r_mag;
      end
      default: begin
        res_hi = 32'd0;
        res_lo = 32'd0;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/md_sched.sv
`default_nettype none
// ============================================================================
// md_sched
// Execute-stage MD sequencer: HI/LO ownership, latency countdown, D-stall.
// Revision: 1.0
// ============================================================================
module md_sched
  import md_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        d_is_md,
  output logic        busy,
  output logic        stall_d,
  output logic [31:0] rd_data,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [3:0] C_MULT_LOAD = 4'(MULT_CYCLES - 1);
  localparam logic [3:0] C_DIV_LOAD  = 4'(DIV_CYCLES - 1);

  md_state_e   state_q, state_d;
  logic [3:0]  count_q, count_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] pend_hi_q, pend_hi_d;
  logic [31:0] pend_lo_q, pend_lo_d;
  logic        pend_dz_q, pend_dz_d;

  logic [31:0] w_res_hi;
  logic [31:0] w_res_lo;
  logic        w_div_zero;

  md_arith u_arith (
    .op       (op),
    .a        (src_a),
    .b        (src_b),
    .res_hi   (w_res_hi),
    .res_lo   (w_res_lo),
    .div_zero (w_div_zero)
  );

  // State, countdown, pending result and HI/LO registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      count_q   <= 4'd0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      pend_hi_q <= 32'd0;
      pend_lo_q <= 32'd0;
      pend_dz_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_dz_q <= pend_dz_d;
    end
  end

  // Next-state: issue from IDLE, count down in RUN, commit when count hits 0.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_dz_d = pend_dz_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (is_md_long(op)) begin
            pend_hi_d = w_res_hi;
            pend_lo_d = w_res_lo;
            // Only a divide by zero suppresses the commit.
            pend_dz_d = op[1] & w_div_zero;
            count_d   = op[1] ? C_DIV_LOAD : C_MULT_LOAD;
            state_d   = ST_RUN;
          end else if (op == OP_MTHI) begin
            hi_d = src_a;
          end else if (op == OP_MTLO) begin
            lo_d = src_a;
          end
        end
      end
      ST_RUN: begin
        if (count_q == 4'd0) begin
          if (!pend_dz_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end
          state_d = ST_IDLE;
        end else begin
          count_d = count_q - 4'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy    = (state_q == ST_RUN);
  assign stall_d = d_is_md & (busy | (start & is_md_long(op)));
  assign rd_data = (op == OP_MFHI) ? hi_q : lo_q;
  assign hi      = hi_q;
  assign lo      = lo_q;

`ifndef SYNTHESIS
  // An issue while busy means the hazard unit failed to stall upstream.
  always @(posedge clk) begin
    if (reset && start && busy) begin
      $error("md_sched: start asserted while busy; request ignored");
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_md_sched.sv
`default_nettype none
// ============================================================================
// tb_md_sched
// Directed self-checking bench for md_sched.
// Revision: 1.0
// ============================================================================
module tb_md_sched;
  import md_pkg::*;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        d_is_md;
  logic        busy;
  logic        stall_d;
  logic [31:0] rd_data;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_tests;
  int n_fail;

  md_sched #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .op      (op),
    .src_a   (src_a),
    .src_b   (src_b),
    .d_is_md (d_is_md),
    .busy    (busy),
    .stall_d (stall_d),
    .rd_data (rd_data),
    .hi      (hi),
    .lo      (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge, leaving time to settle.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue a long op, count busy/stall cycles, then check committed HI/LO.
  task automatic run_long(input string tag, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input int exp_n,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int n;
    int n_stall;
    start = 1'b1; op = o; src_a = a; src_b = b;
    #1;
    if (d_is_md) check({tag, "_stall_issue"}, {31'd0, stall_d}, 32'd1);
    step();
    start = 1'b0; op = OP_MFLO;
    #1;
    n = 0;
    n_stall = 0;
    while (busy && n < 40) begin
      n++;
      if (stall_d) n_stall++;
      step();
      #1;
    end
    check({tag, "_busy_cycles"}, 32'(n), 32'(exp_n));
    check({tag, "_stall_cycles"}, 32'(n_stall), d_is_md ? 32'(exp_n) : 32'd0);
    check({tag, "_stall_after"}, {31'd0, stall_d}, 32'd0);
    check({tag, "_hi"}, hi, exp_hi);
    check({tag, "_lo"}, lo, exp_lo);
  endtask

  // Single-cycle op (MTHI/MTLO): issue, verify no busy cycle follows.
  task automatic run_short(input string tag, input logic [2:0] o, input logic [31:0] a);
    start = 1'b1; op = o; src_a = a; src_b = 32'd0;
    #1;
    check({tag, "_stall"}, {31'd0, stall_d}, 32'd0);
    step();
    start = 1'b0; op = OP_MFLO;
    #1;
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset   = 1'b0;
    start   = 1'b0;
    op      = OP_MFLO;
    src_a   = 32'd0;
    src_b   = 32'd0;
    d_is_md = 1'b0;
    step();
    step();
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_stall", {31'd0, stall_d}, 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    check("rst_rd", rd_data, 32'd0);
    reset = 1'b1;
    step();

    run_long("mult_neg", OP_MULT, 32'hFFFFFFFD, 32'd5, 5, 32'hFFFFFFFF, 32'hFFFFFFF1);
    run_long("divu", OP_DIVU, 32'd7, 32'd2, 10, 32'd1, 32'd3);
    run_long("div_neg", OP_DIV, 32'hFFFFFFF9, 32'd2, 10, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_long("div_ovf", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 10, 32'd0, 32'h80000000);

    run_short("mthi", OP_MTHI, 32'h12345678);
    run_short("mtlo", OP_MTLO, 32'h9ABCDEF0);
    check("pre_hi", hi, 32'h12345678);
    check("pre_lo", lo, 32'h9ABCDEF0);
    run_long("div0", OP_DIV, 32'd5, 32'd0, 10, 32'h12345678, 32'h9ABCDEF0);

    d_is_md = 1'b1;
    run_long("multu", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5, 32'hFFFFFFFE, 32'h00000001);
    op = OP_MFLO; start = 1'b1;
    #1;
    check("mflo_rd", rd_data, 32'h00000001);
    check("mflo_stall", {31'd0, stall_d}, 32'd0);
    op = OP_MFHI;
    #1;
    check("mfhi_rd", rd_data, 32'hFFFFFFFE);
    step();
    start = 1'b0;

    run_short("mthi2", OP_MTHI, 32'hDEADBEEF);
    op = OP_MFHI; start = 1'b1;
    #1;
    check("mfhi2_rd", rd_data, 32'hDEADBEEF);
    step();
    start = 1'b0;
    d_is_md = 1'b0;

    // Asynchronous reset in the middle of a divide.
    start = 1'b1; op = OP_DIV; src_a = 32'd100; src_b = 32'd7;
    step();
    start = 1'b0; op = OP_MFLO;
    step();
    step();
    check("mid_busy", {31'd0, busy}, 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_hi", hi, 32'd0);
    check("arst_lo", lo, 32'd0);
    step();
    reset = 1'b1;
    step();
    run_long("mult_67", OP_MULT, 32'd6, 32'd7, 5, 32'd0, 32'd42);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/md_sched.md
Name: md_sched

Overview:
- Execute-stage sequencer for the multiply/divide resource; owns the HI/LO registers.
- Accepts one MD operation per issue, models fixed multi-cycle latency with a countdown, commits results to HI/LO at completion, and serves MFHI/MFLO reads.
- Generates the decode-stage stall request consumed by the hazard unit, so MD-class instructions wait while the unit is occupied.

Parameters:
- MULT_CYCLES, 5, busy cycles for MULT/MULTU (legal range 1..15).
- DIV_CYCLES, 10, busy cycles for DIV/DIVU (legal range 1..15).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset (low = reset asserted).
- start  in  1  E-stage issue strobe, one cycle per instruction.
- op  in  3  md_pkg op code: MULT, MULTU, DIV, DIVU, MTHI, MTLO, MFHI, MFLO, sampled with start.
- src_a  in  32  forwarded rs value.
- src_b  in  32  forwarded rt value.
- d_is_md  in  1  instruction in D is MD-class: any of the 8 ops.
- busy  out  1  multi-cycle operation in flight.
- stall_d  out  1  = d_is_md & (busy | (start & op is MULT/MULTU/DIV/DIVU)).
- rd_data  out  32  HI when op==MFHI, else LO; combinational from the current HI/LO registers.
- hi  out  32  HI register.
- lo  out  32  LO register.

Behaviour:
- Reset (reset low, asynchronous): state=IDLE, count=0, busy=0, hi=0, lo=0, pending regs=0. rd_data follows hi/lo, so it is 0. stall_d is combinational and stays 0 while d_is_md and start are 0.
- FSM states: IDLE and RUN.
- IDLE + start + MULT/MULTU/DIV/DIVU:
  - Compute the result combinationally and latch it into pend_hi/pend_lo at the edge.
  - count <= MULT_CYCLES-1 or DIV_CYCLES-1 for the op.
  - Go to RUN; busy rises in the next cycle.
- RUN: count decrements each cycle. When count==0 at an edge: hi<=pend_hi, lo<=pend_lo, go to IDLE.
- Latency: start at cycle t gives busy=1 in cycles t+1..t+N; new hi/lo are visible and busy=0 from cycle t+N+1, where N = MULT_CYCLES or DIV_CYCLES.
- MTHI/MTLO with start in IDLE: hi (or lo) <= src_a at the edge. No busy cycle.
- MFHI/MFLO: no state change. The pipeline reads rd_data in the same cycle.
- start while busy: an illegal upstream condition, because stall_d prevents it. The request is ignored, hi/lo/pending are untouched, and in simulation the unit raises $error.
- Multiply arithmetic:
  - MULT: 64-bit signed product of src_a and src_b; HI = [63:32], LO = [31:0].
  - MULTU: same, unsigned.
- Divide arithmetic:
  - DIV: signed, quotient truncated toward zero. LO = quotient; HI = remainder, which carries the dividend's sign.
  - DIVU: unsigned.
  - Divisor==0: still occupies DIV_CYCLES, but hi/lo are left unchanged at commit.
  - DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0 (wraps).
- Simultaneous events:
  - Commit edge and start on the same edge cannot occur, because busy=1 during the commit cycle blocks issue.
  - The first issue after completion is legal in cycle t+N+1.
- Reset mid-operation discards pend_hi/pend_lo. hi/lo return to 0.

Decomposition:
- md_pkg holds:
  - The 3-bit op encoding: MULT=0, MULTU=1, DIV=2, DIVU=3, MTHI=4, MTLO=5, MFHI=6, MFLO=7.
  - An is_md_long(op) function.
  - The state enum (IDLE, RUN).
- Sub-module md_arith (purely combinational):
  - Inputs: op, a, b.
  - Outputs: res_hi, res_lo, div_zero.
  - Isolates the signed/unsigned product and quotient logic from the sequencer FSM.

Test Plan:
- MULT a=0xFFFFFFFD(-3), b=5 -> busy high exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- DIVU 7/2 -> busy high 10 cycles; then lo=3, hi=1. DIV 0xFFFFFFF9(-7)/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- Preload via MTHI 0x12345678 and MTLO 0x9ABCDEF0, then DIV by 0 -> busy for 10 cycles; then hi=0x12345678, lo=0x9ABCDEF0.
- MULTU issued with d_is_md=1 held -> stall_d=1 in the issue cycle and for all 5 busy cycles, 0 in cycle t+6; MFLO then returns rd_data=product low word.
- MTHI a=0xDEADBEEF (busy stays 0), next cycle MFHI -> rd_data=0xDEADBEEF.
- Pull reset low at cycle t+3 of a DIV -> busy, hi and lo read 0 immediately (asynchronously); after release, MULT 6*7 yields lo=42, hi=0.
